// File: rtl/matmul_tile_sched_if.sv
// Command channel between the tile scheduler and the load/compute/store
// engines: valid/ready command issue plus a one-cycle completion pulse.
interface matmul_tile_sched_if #(
  parameter int DIM_W = 16,
  parameter int LEN_W = 3
);
  logic             cmd_valid;
  logic             cmd_ready;
  logic [1:0]       cmd_op;
  logic [DIM_W-1:0] cmd_tm;
  logic [DIM_W-1:0] cmd_tn;
  logic [DIM_W-1:0] cmd_tk;
  logic [LEN_W-1:0] cmd_len_m;
  logic [LEN_W-1:0] cmd_len_n;
  logic [LEN_W-1:0] cmd_len_k;
  logic             cmd_first_k;
  logic             cmd_last_k;
  logic             op_done;

  modport master (
    output cmd_valid, cmd_op,
    output cmd_tm, cmd_tn, cmd_tk,
    output cmd_len_m, cmd_len_n, cmd_len_k,
    output cmd_first_k, cmd_last_k,
    input  cmd_ready, op_done
  );

  modport slave (
    input  cmd_valid, cmd_op,
    input  cmd_tm, cmd_tn, cmd_tk,
    input  cmd_len_m, cmd_len_n, cmd_len_k,
    input  cmd_first_k, cmd_last_k,
    output cmd_ready, op_done
  );
endinterface

// File: rtl/matmul_tile_sched.sv
// Tile scheduler: walks tm/tn/tk tiles of an MxK * KxN matmul and issues
// LOAD_A, LOAD_B, COMPUTE, STORE_C one at a time to the datapath.
module matmul_tile_sched #(
  parameter int TILE  = 4,
  parameter int DIM_W = 16,
  parameter int LEN_W = $clog2(TILE) + 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic                abort,
  input  logic [DIM_W-1:0]    dim_m,
  input  logic [DIM_W-1:0]    dim_n,
  input  logic [DIM_W-1:0]    dim_k,
  output logic                busy,
  output logic                done_o,
  output logic                cfg_err,
  matmul_tile_sched_if.master cmd
);
  localparam int SH = $clog2(TILE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] FIN   = 2'd3;

  localparam logic [1:0] OP_A = 2'd0;
  localparam logic [1:0] OP_B = 2'd1;
  localparam logic [1:0] OP_C = 2'd2;
  localparam logic [1:0] OP_S = 2'd3;

  logic [1:0]       state, phase;
  logic [DIM_W-1:0] m_q, n_q, k_q;
  logic [DIM_W-1:0] tcm, tcn, tck;
  logic [DIM_W-1:0] tm, tn, tk;

  function automatic logic [DIM_W-1:0] tiles(
    input logic [DIM_W-1:0] d
  );
    logic [DIM_W:0] s;
    s = {1'b0, d} + (DIM_W+1)'(TILE - 1);
    return DIM_W'(s >> SH);
  endfunction

  function automatic logic [LEN_W-1:0] tlen(
    input logic [DIM_W-1:0] d,
    input logic [DIM_W-1:0] idx
  );
    logic [DIM_W-1:0] r;
    r = d - (idx << SH);
    return (r >= DIM_W'(TILE)) ? LEN_W'(TILE)
                               : r[LEN_W-1:0];
  endfunction

  logic             zero_dim, halt;
  logic             last_job, load;
  logic [1:0]       nph, s_ph;
  logic [DIM_W-1:0] ntm, ntn, ntk;
  logic [DIM_W-1:0] s_tm, s_tn, s_tk;
  logic [DIM_W-1:0] s_m, s_n, s_k, s_tck;

  assign zero_dim = (dim_m == '0) || (dim_n == '0)
                 || (dim_k == '0);
  assign halt = busy && abort;

  // Loop nest step: tk innermost, STORE_C closes each (tm,tn).
  always_comb begin
    nph      = phase;
    ntm      = tm;
    ntn      = tn;
    ntk      = tk;
    last_job = 1'b0;
    unique case (phase)
      OP_A: nph = OP_B;
      OP_B: nph = OP_C;
      OP_C: begin
        if (tk == tck - 1'b1) begin
          nph = OP_S;
        end else begin
          nph = OP_A;
          ntk = tk + 1'b1;
        end
      end
      default: begin
        nph = OP_A;
        ntk = '0;
        if (tn == tcn - 1'b1) begin
          ntn = '0;
          if (tm == tcm - 1'b1) last_job = 1'b1;
          else                  ntm = tm + 1'b1;
        end else begin
          ntn = tn + 1'b1;
        end
      end
    endcase
  end

  // Source of the next command: job origin on start, else next step.
  always_comb begin
    if (state == IDLE) begin
      s_ph  = OP_A;
      s_tm  = '0;
      s_tn  = '0;
      s_tk  = '0;
      s_m   = dim_m;
      s_n   = dim_n;
      s_k   = dim_k;
      s_tck = tiles(dim_k);
    end else begin
      s_ph  = nph;
      s_tm  = ntm;
      s_tn  = ntn;
      s_tk  = ntk;
      s_m   = m_q;
      s_n   = n_q;
      s_k   = k_q;
      s_tck = tck;
    end
  end

  assign load = !halt &&
    ((state == IDLE && start && !zero_dim) ||
     (state == WAIT && cmd.op_done && !last_job));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      phase         <= OP_A;
      busy          <= 1'b0;
      done_o        <= 1'b0;
      cfg_err       <= 1'b0;
      cmd.cmd_valid <= 1'b0;
      m_q           <= '0;
      n_q           <= '0;
      k_q           <= '0;
      tcm           <= '0;
      tcn           <= '0;
      tck           <= '0;
      tm            <= '0;
      tn            <= '0;
      tk            <= '0;
    end else if (halt) begin
      state         <= IDLE;
      busy          <= 1'b0;
      cmd.cmd_valid <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (start) begin
          m_q <= dim_m;
          n_q <= dim_n;
          k_q <= dim_k;
          if (zero_dim) begin
            cfg_err <= 1'b1;
          end else begin
            cfg_err       <= 1'b0;
            done_o        <= 1'b0;
            busy          <= 1'b1;
            tcm           <= tiles(dim_m);
            tcn           <= tiles(dim_n);
            tck           <= tiles(dim_k);
            tm            <= '0;
            tn            <= '0;
            tk            <= '0;
            phase         <= OP_A;
            state         <= ISSUE;
            cmd.cmd_valid <= 1'b1;
          end
        end
        ISSUE: if (cmd.cmd_ready) begin
          cmd.cmd_valid <= 1'b0;
          state         <= WAIT;
        end
        WAIT: if (cmd.op_done) begin
          if (last_job) begin
            state <= FIN;
          end else begin
            phase         <= nph;
            tm            <= ntm;
            tn            <= ntn;
            tk            <= ntk;
            state         <= ISSUE;
            cmd.cmd_valid <= 1'b1;
          end
        end
        default: begin
          busy   <= 1'b0;
          done_o <= 1'b1;
          state  <= IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cmd.cmd_op      <= '0;
      cmd.cmd_tm      <= '0;
      cmd.cmd_tn      <= '0;
      cmd.cmd_tk      <= '0;
      cmd.cmd_len_m   <= '0;
      cmd.cmd_len_n   <= '0;
      cmd.cmd_len_k   <= '0;
      cmd.cmd_first_k <= 1'b0;
      cmd.cmd_last_k  <= 1'b0;
    end else if (load) begin
      cmd.cmd_op      <= s_ph;
      cmd.cmd_tm      <= s_tm;
      cmd.cmd_tn      <= s_tn;
      cmd.cmd_tk      <= s_tk;
      cmd.cmd_len_m   <= tlen(s_m, s_tm);
      cmd.cmd_len_n   <= tlen(s_n, s_tn);
      cmd.cmd_len_k   <= tlen(s_k, s_tk);
      cmd.cmd_first_k <= (s_ph == OP_C) && (s_tk == '0);
      cmd.cmd_last_k  <= (s_ph == OP_C)
                      && (s_tk == s_tck - 1'b1);
    end
  end
endmodule

// File: doc/matmul_tile_sched.md
Name: matmul_tile_sched

Overview:
- Tile scheduler that sequences the TILE×TILE systolic matmul datapath for arbitrary M×K × K×N problems.
- Splits the problem into tiles and issues one command at a time to the load/compute/store engines: LOAD_A, LOAD_B, COMPUTE, STORE_C.
- Waits for each command's completion pulse before issuing the next command.
- Sits between the AXI-lite register bank (dims, start, done) and the DMA/array datapath.

Parameters:
- TILE, 4, systolic array edge; power of two, ≥2.
- DIM_W, 16, width of dimension registers and tile indices.
- LEN_W, $clog2(TILE)+1, width of per-tile length fields.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; asynchronous, active-low
- start  in  1  one-cycle launch pulse; dims sampled this cycle
- abort  in  1  cancel the current job
- dim_m  in  DIM_W  rows of A and C
- dim_n  in  DIM_W  cols of B and C
- dim_k  in  DIM_W  inner dimension
- busy  out  1  job in progress
- done_o  out  1  job complete; level signal
- cfg_err  out  1  last start rejected because a dim was zero
- cmd_valid  out  1  command valid
- cmd_ready  in  1  datapath accepts command
- cmd_op  out  2  0=LOAD_A, 1=LOAD_B, 2=COMPUTE, 3=STORE_C
- cmd_tm, cmd_tn, cmd_tk  out  DIM_W each  tile indices
- cmd_len_m, cmd_len_n, cmd_len_k  out  LEN_W each  valid extent of the current tile
- cmd_first_k  out  1  COMPUTE: clear accumulators first
- cmd_last_k  out  1  COMPUTE: final K tile
- op_done  in  1  one-cycle pulse; accepted command finished

Behaviour:
- Reset values: every output 0. Internal state goes to IDLE.
- States:
  - IDLE
  - ISSUE: cmd_valid=1
  - WAIT: waiting for op_done
  - FIN
- IDLE + start:
  - Latch dims.
  - If any dim is 0: set cfg_err=1, stay in IDLE, no commands, done_o unchanged.
  - Otherwise: cfg_err=0, done_o=0, busy=1, tm=tn=tk=0, phase=LOAD_A, go to ISSUE next cycle.
- Tile counts: TM=ceil(M/TILE), TN=ceil(N/TILE), TK=ceil(K/TILE), computed by add-and-shift.
- Tile lengths: len_x = min(TILE, dim_x − idx·TILE).
- Loop order, tm outer, tn middle, tk inner:
  - LOAD_A(tm,tk)
  - LOAD_B(tk,tn)
  - COMPUTE(tm,tn,tk), with first_k=(tk==0) and last_k=(tk==TK−1)
  - After the last tk: STORE_C(tm,tn)
  - Then advance tn, then tm.
- Command handshake:
  - In ISSUE, all cmd_* fields are registered and held stable while cmd_valid=1 and cmd_ready=0.
  - Transfer occurs when cmd_valid && cmd_ready. Next cycle: cmd_valid=0, state=WAIT.
  - first_k and last_k are 0 for non-COMPUTE ops.
- WAIT:
  - op_done advances the phase/indices. Next cycle goes to ISSUE, or to FIN after the last STORE_C.
  - Minimum gap from op_done to the next cmd_valid is 1 cycle.
- op_done outside WAIT is ignored, including in the same cycle as the cmd handshake.
- FIN: busy=0, done_o=1, then IDLE.
  - done_o stays high until the next accepted start. It clears on an accepted start, not on one rejected for a zero dim.
- start while busy: ignored.
- abort while busy, highest priority, any state:
  - Next cycle: cmd_valid=0, busy=0, state=IDLE.
  - done_o stays 0 and cfg_err is unchanged.
  - Any op_done that arrives later is ignored.
- abort in IDLE: no effect.
- start and abort in the same cycle while in IDLE: start wins.
- rst_n low mid-job: immediate clear to reset values. No command is reissued.
- Total commands per job = TM·TN·(3·TK+1).
- Index counters never wrap past TM−1, TN−1 or TK−1.

Test Plan:
- TILE=4, M=N=K=4, cmd_ready=1, op_done 3 cycles after each accept:
  - Commands are LOAD_A(0,0), LOAD_B(0,0), COMPUTE(first=1, last=1), STORE_C(0,0).
  - Then done_o=1 and busy=0; done_o stays high for 20 idle cycles.
- M=8, N=4, K=8:
  - 14 commands.
  - COMPUTE flags are (1,0) then (0,1) for each tm.
  - STORE_C order is (0,0) then (1,0).
- M=5, N=3, K=6:
  - tm=1 tiles carry len_m=1; all tiles carry len_n=3; tk=1 tiles carry len_k=2.
  - Command count is 2·1·7=14.
- Backpressure: hold cmd_ready=0 for 7 cycles on the 2nd command.
  - cmd_valid and all fields stay stable.
  - Exactly one transfer occurs.
  - A spurious op_done during ISSUE causes no advance.
- start with K=0:
  - cfg_err=1, no cmd_valid for 50 cycles, busy=0.
  - A following valid start clears cfg_err and completes normally.
- Abort during WAIT of the 6th command:
  - busy=0 next cycle; the late op_done is ignored; done_o=0.
  - A new start with 4,4,4 completes with 4 commands.
- Assert rst_n mid-ISSUE: all outputs are 0 asynchronously.
